// File: rtl/rv32i_types.sv
// Shared types for the cache-to-memory path: arbiter states, grant select,
// line geometry and a line-alignment helper.
package rv32i_types;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } grant_sel_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-cache
// and D-cache, with per-requester completed-transaction counters.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [CNT_W-1:0]  i_grants,
  output logic [CNT_W-1:0]  d_grants
);

  arb_state_e state_q, state_d;
  grant_sel_e last_q, last_d;
  logic       d_req;
  logic       i_done;
  logic       d_done;
  logic       unused_addr_bits;

  assign d_req  = d_read || d_write;
  assign i_done = (state_q == GNT_I) && pmem_resp;
  assign d_done = (state_q == GNT_D) && pmem_resp;

  // Every grant returns through IDLE, which guarantees a strobe-free gap.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (i_read && d_req) begin
          state_d = (last_q == SEL_D) ? GNT_I : GNT_D;
        end else if (i_read) begin
          state_d = GNT_I;
        end else if (d_req) begin
          state_d = GNT_D;
        end
      end
      GNT_I: begin
        if (pmem_resp) begin
          state_d = IDLE;
          last_d  = SEL_I;
        end
      end
      GNT_D: begin
        if (pmem_resp) begin
          state_d = IDLE;
          last_d  = SEL_D;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= SEL_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Memory-side strobes and responses follow the granted requester directly.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state_q)
      GNT_I: begin
        pmem_read    = 1'b1;
        pmem_address = line_align(i_address);
        i_resp       = pmem_resp;
      end
      GNT_D: begin
        pmem_write   = d_write;
        pmem_read    = d_read && !d_write;
        pmem_address = line_align(d_address);
        pmem_wdata   = d_wdata;
        d_resp       = pmem_resp;
      end
      default: ;
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  assign unused_addr_bits = ^{i_address[OFFSET_W-1:0], d_address[OFFSET_W-1:0]};

  sat_counter #(.CNT_W(CNT_W)) u_i_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (i_done),
    .count (i_grants)
  );

  sat_counter #(.CNT_W(CNT_W)) u_d_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (d_done),
    .count (d_grants)
  );

  // Requesters must hold their request until the response arrives.
  a_i_hold : assert property (@(posedge clk) disable iff (rst) (state_q == GNT_I) |-> i_read);
  a_d_hold : assert property (@(posedge clk) disable iff (rst) (state_q == GNT_D) |-> d_req);

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed requests feed requester agents,
// expected memory transactions are queued and checked by an independent monitor.
module tb_cache_arbiter;
  import rv32i_types::*;

  localparam int unsigned CNT_W = 32;

  typedef struct {
    logic         is_d;
    logic         rd;
    logic         wr;
    logic [31:0]  addr;
    logic [31:0]  exp_addr;
    logic [255:0] wdata;
  } item_t;

  logic clk = 1'b0;
  logic rst;
  logic i_read, d_read, d_write;
  logic [31:0] i_address, d_address;
  logic [255:0] d_wdata, pmem_rdata;
  logic pmem_resp;
  logic [255:0] i_rdata, d_rdata, pmem_wdata;
  logic i_resp, d_resp, pmem_read, pmem_write;
  logic [31:0] pmem_address;
  logic [CNT_W-1:0] i_grants, d_grants;

  logic [255:0] sat_unused_i_rdata, sat_unused_d_rdata, sat_unused_pmem_wdata;
  logic sat_unused_i_resp, sat_unused_d_resp, sat_unused_pmem_read, sat_unused_pmem_write;
  logic [31:0] sat_unused_pmem_address;
  logic [1:0] s_i_grants, s_d_grants;

  item_t i_work[$];
  item_t d_work[$];
  item_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int mem_lat = 2;
  bit stray = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .i_grants(i_grants), .d_grants(d_grants)
  );

  // Narrow-counter instance sharing the same traffic, used for saturation.
  cache_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(sat_unused_i_rdata), .i_resp(sat_unused_i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(sat_unused_d_rdata), .d_resp(sat_unused_d_resp),
    .pmem_read(sat_unused_pmem_read), .pmem_write(sat_unused_pmem_write),
    .pmem_address(sat_unused_pmem_address), .pmem_wdata(sat_unused_pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .i_grants(s_i_grants), .d_grants(s_d_grants)
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic item_t mk(input logic is_d, input logic rd, input logic wr,
                               input logic [31:0] addr, input logic [31:0] exp_addr,
                               input logic [255:0] wdata);
    item_t it;
    it.is_d = is_d; it.rd = rd; it.wr = wr;
    it.addr = addr; it.exp_addr = exp_addr; it.wdata = wdata;
    return it;
  endfunction

  task automatic add_i(input logic [31:0] addr, input logic [31:0] exp_addr);
    i_work.push_back(mk(1'b0, 1'b1, 1'b0, addr, exp_addr, '0));
  endtask

  task automatic add_d(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] exp_addr, input logic [255:0] wdata);
    d_work.push_back(mk(1'b1, rd, wr, addr, exp_addr, wdata));
  endtask

  task automatic exp_i(input logic [31:0] exp_addr);
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h0, exp_addr, '0));
  endtask

  task automatic exp_d(input logic wr, input logic [31:0] exp_addr, input logic [255:0] wdata);
    exp_q.push_back(mk(1'b1, !wr, wr, 32'h0, exp_addr, wdata));
  endtask

  // Requester agents plus a fixed-latency memory responder.
  initial begin
    item_t it;
    logic i_done, d_done;
    int mem_cnt;
    i_read = 0; d_read = 0; d_write = 0;
    i_address = '0; d_address = '0; d_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
    mem_cnt = 0;
    forever begin
      @(negedge clk);
      i_done = i_resp;
      d_done = d_resp;
      @(posedge clk);
      #1;
      if (rst) begin
        i_read = 0; d_read = 0; d_write = 0;
        i_work.delete(); d_work.delete();
      end else begin
        if (i_done) i_read = 0;
        if (d_done) begin d_read = 0; d_write = 0; end
        if (!i_read && i_work.size() > 0) begin
          it = i_work.pop_front();
          i_read = 1; i_address = it.addr;
        end
        if (!d_read && !d_write && d_work.size() > 0) begin
          it = d_work.pop_front();
          d_read = it.rd; d_write = it.wr; d_address = it.addr; d_wdata = it.wdata;
        end
      end
      #1;
      pmem_resp = 0;
      if (!rst && (pmem_read || pmem_write)) begin
        mem_cnt++;
        if (mem_cnt == mem_lat) begin
          pmem_resp = 1;
          mem_cnt = 0;
        end
      end else begin
        mem_cnt = 0;
        if (stray) begin
          pmem_resp = 1;
          stray = 0;
        end
      end
      pmem_rdata = pmem_resp ? {8{pmem_address}} : '0;
    end
  end

  // Monitor: pops an expected transaction at each strobe start, checks routing.
  initial begin
    item_t cur;
    bit have_cur = 0;
    bit prev_strobe = 0;
    bit strobe;
    forever begin
      @(negedge clk);
      strobe = pmem_read || pmem_write;
      if (!rst && strobe && !prev_strobe) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 256'(strobe), 256'(0));
          have_cur = 0;
        end else begin
          cur = exp_q.pop_front();
          have_cur = 1;
          check("pmem_write", 256'(pmem_write), 256'(cur.wr));
          check("pmem_read", 256'(pmem_read), 256'(!cur.wr));
          check("pmem_address", 256'(pmem_address), 256'(cur.exp_addr));
          if (cur.wr) check("pmem_wdata", pmem_wdata, cur.wdata);
        end
      end
      if (strobe && have_cur) begin
        if (cur.is_d) begin
          check("i_resp_while_d", 256'(i_resp), 256'(0));
          check("d_resp_route", 256'(d_resp), 256'(pmem_resp));
          if (pmem_resp) check("d_rdata", d_rdata, {8{cur.exp_addr}});
        end else begin
          check("d_resp_while_i", 256'(d_resp), 256'(0));
          check("i_resp_route", 256'(i_resp), 256'(pmem_resp));
          if (pmem_resp) check("i_rdata", i_rdata, {8{cur.exp_addr}});
        end
      end else if (!strobe) begin
        check("resp_idle", 256'({i_resp, d_resp}), 256'(0));
      end
      prev_strobe = strobe;
    end
  end

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (i_work.size() == 0 && d_work.size() == 0 && !i_read && !d_read && !d_write &&
          !pmem_read && !pmem_write) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 256'(0), 256'(1));
  endtask

  task automatic wait_high(input string name, input bit want_i);
    bit ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (want_i ? i_read : pmem_write) begin
        ok = 1;
        break;
      end
    end
    if (!ok) check({name, "_timeout"}, 256'(0), 256'(1));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("rst_i_grants", 256'(i_grants), 256'(0));
    check("rst_d_grants", 256'(d_grants), 256'(0));
    #1 rst = 0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    check("reset_pmem_read", 256'(pmem_read), 256'(0));
    check("reset_pmem_write", 256'(pmem_write), 256'(0));
    check("reset_pmem_address", 256'(pmem_address), 256'(0));
    check("reset_resps", 256'({i_resp, d_resp}), 256'(0));
    check("reset_i_grants", 256'(i_grants), 256'(0));
    check("reset_d_grants", 256'(d_grants), 256'(0));
    #1 rst = 0;
    @(negedge clk);

    // I-only read, one-cycle request-to-strobe latency
    add_i(32'h0000_0064, 32'h0000_0060); exp_i(32'h0000_0060);
    wait_high("i_req", 1'b1);
    check("lat_idle_cycle", 256'(pmem_read), 256'(0));
    @(negedge clk);
    check("lat_strobe", 256'(pmem_read), 256'(1));
    check("lat_address", 256'(pmem_address), 256'(32'h0000_0060));
    wait_idle("i_only");
    check("i_only_i_grants", 256'(i_grants), 256'(1));
    check("i_only_d_grants", 256'(d_grants), 256'(0));

    // D write, then D with read+write both asserted (write wins)
    add_d(1'b0, 1'b1, 32'h8000_003C, 32'h8000_0020, {32{8'hA5}});
    exp_d(1'b1, 32'h8000_0020, {32{8'hA5}});
    add_d(1'b1, 1'b1, 32'h4000_0007, 32'h4000_0000, {8{32'hDEAD_BEEF}});
    exp_d(1'b1, 32'h4000_0000, {8{32'hDEAD_BEEF}});
    wait_idle("d_write");
    check("d_write_d_grants", 256'(d_grants), 256'(2));
    check("d_write_i_grants", 256'(i_grants), 256'(1));

    // Stray pmem_resp in IDLE is ignored
    stray = 1;
    repeat (3) @(negedge clk);
    check("stray_i_grants", 256'(i_grants), 256'(1));
    check("stray_d_grants", 256'(d_grants), 256'(2));

    // Tie after reset: I first, then D
    do_reset();
    add_i(32'h0000_0100, 32'h0000_0100);
    add_d(1'b1, 1'b0, 32'h0000_0210, 32'h0000_0200, '0);
    exp_i(32'h0000_0100); exp_d(1'b0, 32'h0000_0200, '0);
    wait_idle("tie");
    check("tie_i_grants", 256'(i_grants), 256'(1));
    check("tie_d_grants", 256'(d_grants), 256'(1));

    // Fairness: continuous requests alternate I,D,I,D,I,D
    do_reset();
    add_i(32'h0000_1000, 32'h0000_1000);
    add_i(32'h0000_1024, 32'h0000_1020);
    add_i(32'h0000_1040, 32'h0000_1040);
    add_d(1'b1, 1'b0, 32'h0000_2000, 32'h0000_2000, '0);
    add_d(1'b0, 1'b1, 32'h0000_2044, 32'h0000_2040, {8{32'h1234_5678}});
    add_d(1'b1, 1'b0, 32'h0000_2088, 32'h0000_2080, '0);
    exp_i(32'h0000_1000); exp_d(1'b0, 32'h0000_2000, '0);
    exp_i(32'h0000_1020); exp_d(1'b1, 32'h0000_2040, {8{32'h1234_5678}});
    exp_i(32'h0000_1040); exp_d(1'b0, 32'h0000_2080, '0);
    wait_idle("fair");
    check("fair_i_grants", 256'(i_grants), 256'(3));
    check("fair_d_grants", 256'(d_grants), 256'(3));

    // Reset in the middle of a D write abandons it silently
    mem_lat = 100;
    add_d(1'b0, 1'b1, 32'h0000_3000, 32'h0000_3000, {32{8'h55}});
    exp_d(1'b1, 32'h0000_3000, {32{8'h55}});
    wait_high("mid_strobe", 1'b0);
    repeat (2) @(negedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("mid_pmem_write", 256'(pmem_write), 256'(0));
    check("mid_pmem_read", 256'(pmem_read), 256'(0));
    check("mid_d_resp", 256'(d_resp), 256'(0));
    check("mid_state", 256'(dut.state_q), 256'(IDLE));
    check("mid_i_grants", 256'(i_grants), 256'(0));
    check("mid_d_grants", 256'(d_grants), 256'(0));
    #1 rst = 0;
    mem_lat = 2;
    @(negedge clk);

    // Saturation: five I transactions on a 2-bit counter stay at 3
    for (int k = 0; k < 5; k++) begin
      add_i(32'h0000_4000 + 32'(k * 32), 32'h0000_4000 + 32'(k * 32));
      exp_i(32'h0000_4000 + 32'(k * 32));
    end
    wait_idle("sat");
    check("sat_i_grants_w2", 256'(s_i_grants), 256'(3));
    check("sat_d_grants_w2", 256'(s_d_grants), 256'(0));
    check("sat_i_grants_w32", 256'(i_grants), 256'(5));

    repeat (2) @(negedge clk);
    check("exp_q_drained", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter: CNT_W, 32, width of the per-requester grant counters.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- i_read  in  1  I-cache line-read request, held until i_resp.
- i_address  in  32  I-cache byte address.
- i_rdata  out  256  I-cache line data.
- i_resp  out  1  I-cache completion pulse.
- d_read  in  1  D-cache line-read request, held until d_resp.
- d_write  in  1  D-cache line-write request, held until d_resp.
- d_address  in  32  D-cache byte address.
- d_wdata  in  256  D-cache write line.
- d_rdata  out  256  D-cache line data.
- d_resp  out  1  D-cache completion pulse.
- pmem_read  out  1  read strobe to the cacheline adaptor / burst memory.
- pmem_write  out  1  write strobe to the adaptor.
- pmem_address  out  32  line-aligned address to the adaptor.
- pmem_wdata  out  256  write line to the adaptor.
- pmem_rdata  in  256  read line from the adaptor.
- pmem_resp  in  1  adaptor completion pulse.
- i_grants  out  CNT_W  completed I-cache transactions.
- d_grants  out  CNT_W  completed D-cache transactions.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, GNT_I, GNT_D.
REQ-004 In IDLE, with only i_read asserted, the next state SHALL be GNT_I; with only (d_read or d_write) asserted, GNT_D; with neither, IDLE.
REQ-005 In IDLE, with both requesters asserted, the grant SHALL go to the requester not granted last (round-robin); last_grant resets to D, so the I-cache wins the first tie.
REQ-006 In IDLE, all pmem strobes and both resp outputs SHALL be 0.
REQ-007 In GNT_I, pmem_read SHALL be 1, pmem_write SHALL be 0 and pmem_address SHALL be {i_address[31:5], 5'b0}, all combinational from state.
REQ-008 In GNT_D, the strobes SHALL be driven as follows:
- pmem_write = d_write.
- pmem_read = d_read and not d_write; write takes precedence if both are asserted.
- pmem_address = {d_address[31:5], 5'b0}.
- pmem_wdata = d_wdata.
REQ-009 pmem_resp SHALL be forwarded combinationally, in the same cycle, to the granted requester's resp only; the non-granted resp SHALL be 0.
REQ-010 pmem_rdata SHALL drive both i_rdata and d_rdata unconditionally.
REQ-011 On a rising edge with pmem_resp=1 in GNT_I or GNT_D, the FSM SHALL return to IDLE and update last_grant.
REQ-012 An IDLE cycle SHALL separate every two transactions, so strobes deassert for at least one cycle; minimum request-to-strobe latency is 1 cycle.
REQ-013 A grant state SHALL be held until pmem_resp, even if the requester deasserts mid-transaction; a withdrawal is a protocol violation, flagged by an assertion.
REQ-014 pmem_resp received in IDLE SHALL be ignored.
REQ-015 i_grants and d_grants SHALL increment by 1 on each completed transaction of that requester and saturate at all-ones.

Reset
REQ-016 On rst=1 at a rising edge the following values SHALL be loaded, with all outputs 0 in the following cycle:
- state = IDLE.
- last_grant = D.
- i_grants = 0 and d_grants = 0.
REQ-017 Reset asserted mid-transaction SHALL abandon the transaction without issuing a resp.

Structure
REQ-018 The state enum, the grant-select typedef, LINE_W=256 and OFFSET_W=5 SHALL live in the shared rv32i_types package.
REQ-019 The block SHALL be a single module, with one small sub-module sat_counter (parameter CNT_W) instantiated once per requester.

Verification
REQ-020 Directed scenarios the bench SHALL cover:
- I-only: i_read=1, i_address=0x0000_0064 -> pmem_read=1 and pmem_address=0x0000_0060 next cycle; i_resp coincides with pmem_resp; i_grants=1.
- D write: d_write=1, d_address=0x8000_003C, d_wdata=0xA5...A5 -> pmem_write=1, pmem_address=0x8000_0020, pmem_wdata matches; d_resp on pmem_resp; i_resp=0 throughout.
- Tie after reset: i_read and d_read both asserted in IDLE -> GNT_I first; after i_resp, one IDLE cycle, then GNT_D.
- Fairness: both requesters asserted continuously for 6 transactions -> grants strictly alternate I,D,I,D,I,D; i_grants=d_grants=3.
- Reset mid-GNT_D (rst after 3 cycles of wait) -> next cycle pmem_write=0, state IDLE, counters 0, no d_resp.
- Saturation: CNT_W=2 with 5 I transactions -> i_grants stays at 3.
